// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial carry-skip adder: sequencer states
// and the nibble width used by both the datapath and the sequencer.
package adder_pkg;

    localparam int unsigned NibbleW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Width of an index over `nibbles` items; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/Carry_Skip_Adder.sv
// Purely combinational 4-bit carry-skip adder slice: ripple carry inside the
// nibble, with the carry-in bypassing the chain when every bit propagates.
module Carry_Skip_Adder
    import adder_pkg::*;
(
    input  logic [NibbleW-1:0] a,
    input  logic [NibbleW-1:0] b,
    input  logic               cin,
    output logic [NibbleW-1:0] sum,
    output logic               cout
);

    logic [NibbleW-1:0] p;
    logic [NibbleW:0]   c;

    always_comb begin
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        sum  = '0;
        for (int i = 0; i < NibbleW; i++) begin
            sum[i]   = p[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (p[i] & c[i]);
        end
        cout = (&p) ? cin : c[NibbleW];
    end

endmodule

// File: rtl/skip_adder_sequencer.sv
// Nibble-serial adder/subtractor: accepts an operand set, runs one 4-bit
// carry-skip slice per cycle LSB first, then presents the result until taken.
module skip_adder_sequencer
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic                            cin,
    input  logic                            sub,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                sum,
    output logic                            cout,
    output logic                            ovf,
    output logic [$clog2(WIDTH/NibbleW):0]  skip_cnt
);

    localparam int unsigned Nibbles = WIDTH / NibbleW;
    localparam int unsigned IdxW    = idx_width(Nibbles);
    localparam int unsigned CntW    = $clog2(Nibbles) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Nibbles - 1);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [IdxW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic              a_msb_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;
    logic [CntW-1:0]   cnt_q;

    logic [NibbleW-1:0] nib_a;
    logic [NibbleW-1:0] nib_b;
    logic [NibbleW-1:0] nib_sum;
    logic               nib_cout;
    logic               nib_skip;
    logic               last_nib;

    assign nib_a    = a_q[idx_q*NibbleW +: NibbleW];
    assign nib_b    = b_q[idx_q*NibbleW +: NibbleW];
    assign nib_skip = &(nib_a ^ nib_b);
    assign last_nib = (idx_q == LastIdx);

    Carry_Skip_Adder u_nibble_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // DONE spends its first cycle with the result registers settled but not yet
    // presented; out_valid rises on the second DONE cycle.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last_nib) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | cin;
                        a_msb_q <= a[WIDTH-1];
                        idx_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    sum_q[idx_q*NibbleW +: NibbleW] <= nib_sum;
                    carry_q <= nib_cout;
                    if (nib_skip) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (last_nib) begin
                        cout_q <= nib_cout;
                        ovf_q  <= (a_msb_q == b_q[WIDTH-1]) &&
                                  (nib_sum[NibbleW-1] != a_msb_q);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign skip_cnt  = cnt_q;

endmodule

// File: tb/tb_skip_adder_sequencer.sv
// Scoreboard bench for skip_adder_sequencer (WIDTH=16): directed operand sets
// push hand-computed results; a negedge monitor checks whatever the DUT presents.
module tb_skip_adder_sequencer;

    localparam int unsigned W       = 16;
    localparam int          Latency = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [2:0]    skip_cnt;

    skip_adder_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .skip_cnt  (skip_cnt)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic [2:0]   k;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   seen  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compares every presented result cycle against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - exp_q[0].acc), 32'(Latency));
                    seen = 1;
                end
                chk("sum", 32'(sum), 32'(exp_q[0].s));
                chk("cout", 32'(cout), 32'(exp_q[0].c));
                chk("ovf", 32'(ovf), 32'(exp_q[0].o));
                chk("skip_cnt", 32'(skip_cnt), 32'(exp_q[0].k));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Entered just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input logic [2:0] ek, input bit push, input bit hold,
                         output int acc);
        exp_t e;
        int   n;
        a        = ia;
        b        = ib;
        cin      = icin;
        sub      = isub;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        acc = cyc + 1;
        if (push) begin
            e.s = es; e.c = ec; e.o = eo; e.k = ek; e.acc = acc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    int acc1;
    int acc2;
    int n_wait;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", {29'd0, cout, ovf, 1'b0}, 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Accepted on the first edge after release.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 3'd0, 1, 0, acc1);
        drain();
        issue(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 1, 0, acc1);
        drain();
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 3'd3, 1, 0, acc1);
        drain();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 3'd2, 1, 0, acc1);
        drain();
        // cin must be ignored when subtracting.
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 3'd2, 1, 0, acc1);
        drain();
        issue(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 3'd4, 1, 0, acc1);
        drain();

        // Back-pressure: hold out_ready low for 6 cycles with in_valid pulses.
        out_ready = 1'b0;
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 1, 0, acc1);
        n_wait = 0;
        while (!out_valid && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a        = 16'hDEAD;
            b        = 16'hBEEF;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset while processing nibble 2: result discarded.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 0, 0, acc1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_skip", 32'(skip_cnt), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 3'd2, 1, 0, acc1);
        chk("post_rst_accept_edge", 32'(acc1), 32'(cyc));
        drain();

        // Back-to-back with in_valid held high across both operations.
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 1, 1, acc1);
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 1, 0, acc2);
        chk("b2b_accept_gap", 32'(acc2 - acc1), 32'(Latency + 2));
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
